decode_stage: RTL and testbench
===============================

# decode_stage

Pipeline decode stage of the MIPS core. It holds one fetched instruction, reads the register file, and decodes the instruction into the 12-bit one-hot ALU control word and the two ALU operands consumed by the execute stage. It sits between fetch and execute, using the core's valid/allowin handshake on both sides, and stalls on read-after-write hazards against in-flight destinations.

## Interface
Parameters: none. ALU op encoding and opcode/funct constants come from the shared package.
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  discard the held instruction at the next edge
- fs_to_ds_valid  in  1  fetch offers an instruction
- fs_pc  in  32  PC of the offered instruction
- fs_inst  in  32  offered instruction word
- ds_allowin  out  1  decode can accept this cycle
- rf_raddr1  out  5  register file read address, rs
- rf_raddr2  out  5  register file read address, rt
- rf_rdata1  in  32  rs value, combinational
- rf_rdata2  in  32  rt value, combinational
- es_dest, ms_dest, ws_dest  in  5 each  destination registers of the EX, MEM and WB stages; 0 means no pending write
- es_allowin  in  1  execute can accept
- ds_to_es_valid  out  1  decoded instruction offered to execute
- ds_alu_control  out  12  one-hot; bits 0..11 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui
- ds_alu_src1  out  32  ALU operand 1 (shift amount in [4:0] for shifts)
- ds_alu_src2  out  32  ALU operand 2 (the shifted value for shifts)
- ds_dest  out  5  destination register; 0 means none
- ds_pc  out  32  PC of the held instruction
- ds_ri  out  1  held instruction is not recognised

## Operation
- Registers: ds_valid, ds_pc, ds_inst.
- Decoded outputs are combinational from ds_inst.
- Supported instructions:
  - ADDU, ADDIU → add
  - SUBU → sub
  - SLT, SLTI → slt
  - SLTU, SLTIU → sltu
  - AND, ANDI → and
  - OR, ORI → or
  - XOR, XORI → xor
  - NOR → nor
  - SLL, SLLV → sll
  - SRL, SRLV → srl
  - SRA, SRAV → sra
  - LUI → lui
- src1:
  - SLL/SRL/SRA → {27'b0, sa}
  - LUI → 0
  - otherwise → rf_rdata1
- src2:
  - R-type → rf_rdata2
  - ANDI/ORI/XORI/LUI → zero-extended imm
  - other I-type → sign-extended imm
- ds_dest: rd for R-type, rt for I-type.
- Register usage:
  - rs is used by everything except SLL/SRL/SRA/LUI.
  - rt is used by R-type only.
- Unrecognised instruction: ds_ri=1, alu_control=0, dest=0, no register used. It still flows downstream.
- Hazard: a used register is nonzero and equals es_dest, ms_dest or ws_dest. Register $0 never stalls.
- Handshake:
  - ds_ready_go = ~hazard
  - ds_allowin = ~ds_valid | (ds_ready_go & es_allowin)
  - ds_to_es_valid = ds_valid & ds_ready_go & ~flush
- Edge update:
  - flush → ds_valid<=0.
  - else if ds_allowin → ds_valid<=fs_to_ds_valid.
  - ds_pc/ds_inst load when fs_to_ds_valid & ds_allowin & ~flush.
- Output gating: all decoded outputs (alu_control, src1, src2, dest, ri) are 0 when ds_valid=0.

## Timing
- Reset values: ds_valid=0, ds_pc=0, ds_inst=0. Outputs: ds_allowin=1, ds_to_es_valid=0, all decoded outputs 0.
- Latency: an instruction accepted at edge N is offered to execute after edge N. With no hazard and es_allowin=1 it transfers at edge N+1, giving a throughput of 1 per cycle.
- Stall: the held instruction and its outputs stay stable while the hazard persists or es_allowin=0. Fetch input is ignored during a stall.
- Simultaneous transfer and accept: new instruction replaces the old at the same edge, with no bubble.
- Flush with a pending transfer: the transfer is suppressed (ds_to_es_valid forced 0), and ds_valid=0 after the edge.
- Reset mid-operation: the held instruction is dropped immediately (asynchronous).

## Structure
- Shared package holds:
  - ALU op bit indices and the 12-bit width, shared with the ALU
  - opcode and funct constants
- One natural sub-module, inst_decoder, purely combinational. Input: inst. Outputs: alu_control, src1/src2 select, imm extension, dest, rs_used/rt_used, ri.
- decode_stage holds the registers, handshake, hazard compare and operand muxes.

## Test plan
- Reset, then release with no input → ds_allowin=1, ds_to_es_valid=0, ds_alu_control=0.
- ADDIU 0x2423FFFF with rf_rdata1=5 → rf_raddr1=1, control 12'h001, src1=5, src2=0xFFFFFFFF, dest=3, valid for exactly one cycle.
- SRA 0x000520C3 with rf_rdata2=0x80000000 → rf_raddr2=5, control 12'h400, src1=3, src2=0x80000000, dest=4.
- ADDIU above with es_dest=1:
  - ds_to_es_valid=0 and ds_allowin=0 for 3 cycles.
  - es_dest→0 → transfer at the next edge.
  - Repeat with rs=$0 → no stall.
- Back-to-back stream with es_allowin low for 2 cycles → outputs hold, no instruction lost or duplicated. flush while held → dropped, ds_to_es_valid=0.
- LUI 0x3C021234 → control 12'h800, src1=0, src2=0x00001234, dest=2. Word 0xFC000000 → ds_ri=1, control 0, dest 0, no stall.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_stage_pkg
//   Constants shared by the decode stage and the ALU:
//     - bit positions and width of the one-hot ALU control word
//     - MIPS primary opcode and SPECIAL funct values handled by decode
//   No ports; imported with "import decode_stage_pkg::*;".
// -----------------------------------------------------------------------------
package decode_stage_pkg;

   // One-hot ALU control word: one bit per operation.
   localparam int ALU_OP_W = 12;
   typedef logic [ALU_OP_W-1:0] alu_ctrl_t;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_LUI  = 11;

   // Primary opcodes (inst[31:26]).
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0a;
   localparam logic [5:0] OP_SLTIU   = 6'h0b;
   localparam logic [5:0] OP_ANDI    = 6'h0c;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_XORI    = 6'h0e;
   localparam logic [5:0] OP_LUI     = 6'h0f;

   // SPECIAL funct codes (inst[5:0]).
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2a;
   localparam logic [5:0] FN_SLTU = 6'h2b;

   // Control word with only the bit for operation idx set.
   function automatic alu_ctrl_t alu_onehot(input int idx);
      return alu_ctrl_t'(1) << idx;
   endfunction

endpackage

// File: rtl/decode_stage_inst_decoder.sv
// -----------------------------------------------------------------------------
// inst_decoder
//   Purely combinational instruction decoder for the decode stage.
//   Ports:
//     inst          in   32  instruction word
//     alu_control   out  12  one-hot ALU operation (0 when not recognised)
//     src1_is_sa    out   1  operand 1 is the shift amount field (SLL/SRL/SRA)
//     src1_is_zero  out   1  operand 1 is zero (LUI)
//     src2_is_imm   out   1  operand 2 is the extended immediate (I-type)
//     imm_zext      out   1  immediate is zero-extended (ANDI/ORI/XORI/LUI)
//     dest          out   5  destination register, 0 when none
//     rs_used       out   1  instruction reads rs
//     rt_used       out   1  instruction reads rt
//     ri            out   1  instruction not recognised
// -----------------------------------------------------------------------------
module inst_decoder
   import decode_stage_pkg::*;
(
   input  logic [31:0] inst,
   output alu_ctrl_t   alu_control,
   output logic        src1_is_sa,
   output logic        src1_is_zero,
   output logic        src2_is_imm,
   output logic        imm_zext,
   output logic [4:0]  dest,
   output logic        rs_used,
   output logic        rt_used,
   output logic        ri
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] rt;
   logic [4:0] rd;

   assign opcode = inst[31:26];
   assign rt     = inst[20:16];
   assign rd     = inst[15:11];
   assign funct  = inst[5:0];

   always_comb begin
      alu_control  = '0;
      src1_is_sa   = 1'b0;
      src1_is_zero = 1'b0;
      src2_is_imm  = 1'b0;
      imm_zext     = 1'b0;
      dest         = '0;
      rs_used      = 1'b0;
      rt_used      = 1'b0;
      ri           = 1'b0;

      if (opcode == OP_SPECIAL) begin
         case (funct)
            FN_ADDU: alu_control = alu_onehot(ALU_ADD);
            FN_SUBU: alu_control = alu_onehot(ALU_SUB);
            FN_SLT:  alu_control = alu_onehot(ALU_SLT);
            FN_SLTU: alu_control = alu_onehot(ALU_SLTU);
            FN_AND:  alu_control = alu_onehot(ALU_AND);
            FN_NOR:  alu_control = alu_onehot(ALU_NOR);
            FN_OR:   alu_control = alu_onehot(ALU_OR);
            FN_XOR:  alu_control = alu_onehot(ALU_XOR);
            FN_SLLV: alu_control = alu_onehot(ALU_SLL);
            FN_SRLV: alu_control = alu_onehot(ALU_SRL);
            FN_SRAV: alu_control = alu_onehot(ALU_SRA);
            FN_SLL: begin
               alu_control = alu_onehot(ALU_SLL);
               src1_is_sa  = 1'b1;
            end
            FN_SRL: begin
               alu_control = alu_onehot(ALU_SRL);
               src1_is_sa  = 1'b1;
            end
            FN_SRA: begin
               alu_control = alu_onehot(ALU_SRA);
               src1_is_sa  = 1'b1;
            end
            default: ri = 1'b1;
         endcase
         // Constant shifts take their amount from sa, so rs is not read.
         if (!ri) begin
            dest    = rd;
            rt_used = 1'b1;
            rs_used = ~src1_is_sa;
         end
      end else begin
         src2_is_imm = 1'b1;
         case (opcode)
            OP_ADDIU: alu_control = alu_onehot(ALU_ADD);
            OP_SLTI:  alu_control = alu_onehot(ALU_SLT);
            OP_SLTIU: alu_control = alu_onehot(ALU_SLTU);
            OP_ANDI: begin
               alu_control = alu_onehot(ALU_AND);
               imm_zext    = 1'b1;
            end
            OP_ORI: begin
               alu_control = alu_onehot(ALU_OR);
               imm_zext    = 1'b1;
            end
            OP_XORI: begin
               alu_control = alu_onehot(ALU_XOR);
               imm_zext    = 1'b1;
            end
            OP_LUI: begin
               // The ALU performs the shift by 16; decode only supplies imm.
               alu_control  = alu_onehot(ALU_LUI);
               imm_zext     = 1'b1;
               src1_is_zero = 1'b1;
            end
            default: ri = 1'b1;
         endcase
         if (!ri) begin
            dest    = rt;
            rs_used = ~src1_is_zero;
         end
      end
   end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   MIPS pipeline decode stage. Holds one instruction from fetch, reads the
//   register file, stalls on RAW hazards against EX/MEM/WB destinations and
//   offers the decoded ALU control word and operands to execute.
//   Ports:
//     clk, resetn                    clock, asynchronous active-low reset
//     flush                          drop the held instruction at the next edge
//     fs_to_ds_valid, fs_pc, fs_inst instruction offered by fetch
//     ds_allowin                     decode accepts this cycle
//     rf_raddr1/2, rf_rdata1/2       register file read ports (rs, rt)
//     es_dest, ms_dest, ws_dest      in-flight destinations, 0 = none
//     es_allowin                     execute accepts this cycle
//     ds_to_es_valid                 decoded instruction offered to execute
//     ds_alu_control                 one-hot ALU operation
//     ds_alu_src1, ds_alu_src2       ALU operands
//     ds_dest                        destination register, 0 = none
//     ds_pc                          PC of the held instruction
//     ds_ri                          held instruction not recognised
//
//   Handshake: a stage transfers an instruction downstream on a clock edge
//   where the producer's valid and the consumer's allowin are both high.
//   allowin depends on the consumer's own state and the downstream allowin,
//   never on the upstream valid, so no combinational loop forms.
// -----------------------------------------------------------------------------
module decode_stage
   import decode_stage_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             fs_to_ds_valid,
   input  logic [31:0]      fs_pc,
   input  logic [31:0]      fs_inst,
   output logic             ds_allowin,
   output logic [4:0]       rf_raddr1,
   output logic [4:0]       rf_raddr2,
   input  logic [31:0]      rf_rdata1,
   input  logic [31:0]      rf_rdata2,
   input  logic [4:0]       es_dest,
   input  logic [4:0]       ms_dest,
   input  logic [4:0]       ws_dest,
   input  logic             es_allowin,
   output logic             ds_to_es_valid,
   output alu_ctrl_t        ds_alu_control,
   output logic [31:0]      ds_alu_src1,
   output logic [31:0]      ds_alu_src2,
   output logic [4:0]       ds_dest,
   output logic [31:0]      ds_pc,
   output logic             ds_ri
);

   logic        ds_valid;
   logic [31:0] ds_inst;
   logic        ds_ready_go;
   logic        hazard;

   // Instruction fields of the held instruction.
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  sa;
   logic [15:0] imm;

   assign rs  = ds_inst[25:21];
   assign rt  = ds_inst[20:16];
   assign sa  = ds_inst[10:6];
   assign imm = ds_inst[15:0];

   // Decoder outputs.
   alu_ctrl_t  dec_alu_control;
   logic       dec_src1_is_sa;
   logic       dec_src1_is_zero;
   logic       dec_src2_is_imm;
   logic       dec_imm_zext;
   logic [4:0] dec_dest;
   logic       dec_rs_used;
   logic       dec_rt_used;
   logic       dec_ri;

   inst_decoder u_inst_decoder (
      .inst         (ds_inst),
      .alu_control  (dec_alu_control),
      .src1_is_sa   (dec_src1_is_sa),
      .src1_is_zero (dec_src1_is_zero),
      .src2_is_imm  (dec_src2_is_imm),
      .imm_zext     (dec_imm_zext),
      .dest         (dec_dest),
      .rs_used      (dec_rs_used),
      .rt_used      (dec_rt_used),
      .ri           (dec_ri)
   );

   // Register file reads follow the held instruction's fields directly.
   assign rf_raddr1 = rs;
   assign rf_raddr2 = rt;

   // RAW hazard: a source actually read by the instruction matches a pending
   // destination. $0 is excluded since destination 0 means "no write".
   logic rs_hit;
   logic rt_hit;

   assign rs_hit = (rs != 5'd0) &&
                   ((rs == es_dest) || (rs == ms_dest) || (rs == ws_dest));
   assign rt_hit = (rt != 5'd0) &&
                   ((rt == es_dest) || (rt == ms_dest) || (rt == ws_dest));

   assign hazard = ds_valid & ((dec_rs_used & rs_hit) | (dec_rt_used & rt_hit));

   assign ds_ready_go    = ~hazard;
   assign ds_allowin     = ~ds_valid | (ds_ready_go & es_allowin);
   assign ds_to_es_valid = ds_valid & ds_ready_go & ~flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ds_valid <= 1'b0;
         ds_pc    <= '0;
         ds_inst  <= '0;
      end else begin
         if (flush) begin
            ds_valid <= 1'b0;
         end else if (ds_allowin) begin
            ds_valid <= fs_to_ds_valid;
         end
         if (fs_to_ds_valid && ds_allowin && !flush) begin
            ds_pc   <= fs_pc;
            ds_inst <= fs_inst;
         end
      end
   end

   // Operand muxes.
   logic [31:0] imm_ext;
   logic [31:0] src1_sel;
   logic [31:0] src2_sel;

   assign imm_ext = dec_imm_zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};

   always_comb begin
      if (dec_src1_is_sa) begin
         src1_sel = {27'b0, sa};
      end else if (dec_src1_is_zero) begin
         src1_sel = '0;
      end else begin
         src1_sel = rf_rdata1;
      end
   end

   assign src2_sel = dec_src2_is_imm ? imm_ext : rf_rdata2;

   // Decoded outputs read as zero whenever no instruction is held, so an
   // empty stage never shows stale decode of the reset/previous word.
   assign ds_alu_control = ds_valid ? dec_alu_control : '0;
   assign ds_alu_src1    = ds_valid ? src1_sel        : '0;
   assign ds_alu_src2    = ds_valid ? src2_sel        : '0;
   assign ds_dest        = ds_valid ? dec_dest        : '0;
   assign ds_ri          = ds_valid & dec_ri;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

   // ---------------------------------------------------------------- signals
   logic        clk;
   logic        resetn;
   logic        flush;
   logic        fs_to_ds_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
   logic        ds_allowin;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic [4:0]  es_dest;
   logic [4:0]  ms_dest;
   logic [4:0]  ws_dest;
   logic        es_allowin;
   logic        ds_to_es_valid;
   logic [11:0] ds_alu_control;
   logic [31:0] ds_alu_src1;
   logic [31:0] ds_alu_src2;
   logic [4:0]  ds_dest;
   logic [31:0] ds_pc;
   logic        ds_ri;

   int n_cmp = 0;
   int n_mis = 0;

   // Register file model; entry 0 is never written.
   logic [31:0] regs [32];
   assign rf_rdata1 = regs[rf_raddr1];
   assign rf_rdata2 = regs[rf_raddr2];

   decode_stage dut (
      .clk            (clk),
      .resetn         (resetn),
      .flush          (flush),
      .fs_to_ds_valid (fs_to_ds_valid),
      .fs_pc          (fs_pc),
      .fs_inst        (fs_inst),
      .ds_allowin     (ds_allowin),
      .rf_raddr1      (rf_raddr1),
      .rf_raddr2      (rf_raddr2),
      .rf_rdata1      (rf_rdata1),
      .rf_rdata2      (rf_rdata2),
      .es_dest        (es_dest),
      .ms_dest        (ms_dest),
      .ws_dest        (ws_dest),
      .es_allowin     (es_allowin),
      .ds_to_es_valid (ds_to_es_valid),
      .ds_alu_control (ds_alu_control),
      .ds_alu_src1    (ds_alu_src1),
      .ds_alu_src2    (ds_alu_src2),
      .ds_dest        (ds_dest),
      .ds_pc          (ds_pc),
      .ds_ri          (ds_ri)
   );

   // ---------------------------------------------------------- clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------ helpers
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------ reference model
   typedef struct {
      logic [11:0] ctrl;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [4:0]  dest;
      logic        ri;
      logic        rs_used;
      logic        rt_used;
   } ref_t;

   // Decode from the instruction-set rules: pick the operation by mnemonic,
   // then form operands as the architecture describes them.
   function automatic ref_t ref_decode(input logic [31:0] inst);
      ref_t        r;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  f_rs;
      logic [4:0]  f_rt;
      logic [4:0]  f_rd;
      logic [4:0]  f_sa;
      logic [15:0] f_imm;
      int          alu;
      bit          const_shift;
      bit          zext;
      bit          lui;
      op = inst[31:26]; fn = inst[5:0];
      f_rs = inst[25:21]; f_rt = inst[20:16]; f_rd = inst[15:11];
      f_sa = inst[10:6]; f_imm = inst[15:0];
      alu = -1; const_shift = 0; zext = 0; lui = 0;
      if (op == 6'd0) begin
         case (fn)
            6'h21: alu = 0;
            6'h23: alu = 1;
            6'h2a: alu = 2;
            6'h2b: alu = 3;
            6'h24: alu = 4;
            6'h27: alu = 5;
            6'h25: alu = 6;
            6'h26: alu = 7;
            6'h00: begin alu = 8;  const_shift = 1; end
            6'h02: begin alu = 9;  const_shift = 1; end
            6'h03: begin alu = 10; const_shift = 1; end
            6'h04: alu = 8;
            6'h06: alu = 9;
            6'h07: alu = 10;
            default: alu = -1;
         endcase
      end else begin
         case (op)
            6'h09: alu = 0;
            6'h0a: alu = 2;
            6'h0b: alu = 3;
            6'h0c: begin alu = 4;  zext = 1; end
            6'h0d: begin alu = 6;  zext = 1; end
            6'h0e: begin alu = 7;  zext = 1; end
            6'h0f: begin alu = 11; zext = 1; lui = 1; end
            default: alu = -1;
         endcase
      end
      r.ri = (alu < 0);
      r.ctrl = r.ri ? 12'd0 : (12'd1 << alu);
      r.dest = r.ri ? 5'd0 : ((op == 6'd0) ? f_rd : f_rt);
      r.rs_used = !r.ri && !const_shift && !lui;
      r.rt_used = !r.ri && (op == 6'd0);
      if (const_shift)  r.src1 = 32'(f_sa);
      else if (lui)     r.src1 = 32'd0;
      else              r.src1 = regs[f_rs];
      if (op == 6'd0)   r.src2 = regs[f_rt];
      else if (zext)    r.src2 = {16'h0000, f_imm};
      else              r.src2 = {{16{f_imm[15]}}, f_imm};
      return r;
   endfunction

   function automatic bit busy(input logic [4:0] r);
      return (r != 5'd0) && ((r == es_dest) || (r == ms_dest) || (r == ws_dest));
   endfunction

   // Random instruction: all supported forms plus two unrecognised ones,
   // registers kept in 0..7 so hazards are frequent.
   function automatic logic [31:0] gen_inst();
      logic [5:0] op;
      logic [5:0] fn;
      int k;
      k = $urandom_range(0, 22);
      op = 6'd0; fn = 6'd0;
      case (k)
         0: fn = 6'h21;  1: fn = 6'h23;  2: fn = 6'h2a;  3: fn = 6'h2b;
         4: fn = 6'h24;  5: fn = 6'h27;  6: fn = 6'h25;  7: fn = 6'h26;
         8: fn = 6'h00;  9: fn = 6'h02; 10: fn = 6'h03; 11: fn = 6'h04;
         12: fn = 6'h06; 13: fn = 6'h07;
         14: op = 6'h09; 15: op = 6'h0a; 16: op = 6'h0b; 17: op = 6'h0c;
         18: op = 6'h0d; 19: op = 6'h0e; 20: op = 6'h0f;
         21: op = 6'h3f;
         default: fn = 6'h3f;
      endcase
      return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
              (op == 6'd0) ? fn : 6'($urandom_range(0, 63))};
   endfunction

   // ------------------------------------------------------- vector table
   typedef struct {
      logic [31:0] inst;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [11:0] ctrl;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [4:0]  dest;
      logic        ri;
      logic        chk_src;
   } vec_t;

   vec_t vecs [10];

   // Model state for the random phase.
   logic        m_valid;
   logic [31:0] m_inst;
   logic [31:0] m_pc;

   initial begin
      vec_t v;
      ref_t r;
      bit   m_haz;
      bit   m_allow;
      bit   m_to_es;

      //            inst          r1            r2            ra1 ra2 ctrl     src1          src2          dst ri chk
      vecs[0] = '{32'h2423FFFF, 32'd5,        32'd0,        5'd1, 5'd3, 12'h001, 32'd5,        32'hFFFFFFFF, 5'd3, 1'b0, 1'b1};
      vecs[1] = '{32'h000520C3, 32'd0,        32'h80000000, 5'd0, 5'd5, 12'h400, 32'd3,        32'h80000000, 5'd4, 1'b0, 1'b1};
      vecs[2] = '{32'h3C021234, 32'd0,        32'h0000DEAD, 5'd0, 5'd2, 12'h800, 32'd0,        32'h00001234, 5'd2, 1'b0, 1'b1};
      vecs[3] = '{32'hFC000000, 32'd0,        32'd0,        5'd0, 5'd0, 12'h000, 32'd0,        32'd0,        5'd0, 1'b1, 1'b0};
      vecs[4] = '{32'h00221821, 32'd7,        32'd9,        5'd1, 5'd2, 12'h001, 32'd7,        32'd9,        5'd3, 1'b0, 1'b1};
      vecs[5] = '{32'h34C58001, 32'h12345678, 32'd0,        5'd6, 5'd5, 12'h040, 32'h12345678, 32'h00008001, 5'd5, 1'b0, 1'b1};
      vecs[6] = '{32'h2822FFFE, 32'd3,        32'd0,        5'd1, 5'd2, 12'h004, 32'd3,        32'hFFFFFFFE, 5'd2, 1'b0, 1'b1};
      vecs[7] = '{32'h00622004, 32'h11,       32'hF0F0F0F0, 5'd3, 5'd2, 12'h100, 32'h11,       32'hF0F0F0F0, 5'd4, 1'b0, 1'b1};
      vecs[8] = '{32'h00C53823, 32'd10,       32'd3,        5'd6, 5'd5, 12'h002, 32'd10,       32'd3,        5'd7, 1'b0, 1'b1};
      vecs[9] = '{32'h000317C2, 32'd0,        32'hFFFF0000, 5'd0, 5'd3, 12'h200, 32'd31,       32'hFFFF0000, 5'd2, 1'b0, 1'b1};

      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      resetn = 1'b0; flush = 1'b0; fs_to_ds_valid = 1'b0;
      fs_pc = '0; fs_inst = '0; es_dest = '0; ms_dest = '0; ws_dest = '0;
      es_allowin = 1'b1;
      repeat (3) next_cycle();
      resetn = 1'b1;

      // ---- reset state
      @(negedge clk);
      chk("rst_allowin", 32'(ds_allowin), 32'd1);
      chk("rst_to_es", 32'(ds_to_es_valid), 32'd0);
      chk("rst_ctrl", 32'(ds_alu_control), 32'd0);
      chk("rst_src1", ds_alu_src1, 32'd0);
      chk("rst_src2", ds_alu_src2, 32'd0);
      chk("rst_dest", 32'(ds_dest), 32'd0);
      chk("rst_ri", 32'(ds_ri), 32'd0);
      chk("rst_pc", ds_pc, 32'd0);
      next_cycle();

      // ---- table vectors: accept, check for one cycle, then gone
      for (int i = 0; i < 10; i++) begin
         v = vecs[i];
         if (v.inst[25:21] != 5'd0) regs[v.inst[25:21]] = v.r1;
         if (v.inst[20:16] != 5'd0) regs[v.inst[20:16]] = v.r2;
         fs_to_ds_valid = 1'b1;
         fs_inst = v.inst;
         fs_pc = 32'h1000 + 32'(i * 4);
         next_cycle();
         fs_to_ds_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d_to_es", i), 32'(ds_to_es_valid), 32'd1);
         chk($sformatf("v%0d_raddr1", i), 32'(rf_raddr1), 32'(v.ra1));
         chk($sformatf("v%0d_raddr2", i), 32'(rf_raddr2), 32'(v.ra2));
         chk($sformatf("v%0d_ctrl", i), 32'(ds_alu_control), 32'(v.ctrl));
         chk($sformatf("v%0d_dest", i), 32'(ds_dest), 32'(v.dest));
         chk($sformatf("v%0d_ri", i), 32'(ds_ri), 32'(v.ri));
         chk($sformatf("v%0d_pc", i), ds_pc, 32'h1000 + 32'(i * 4));
         if (v.chk_src) begin
            chk($sformatf("v%0d_src1", i), ds_alu_src1, v.src1);
            chk($sformatf("v%0d_src2", i), ds_alu_src2, v.src2);
         end
         next_cycle();
         @(negedge clk);
         chk($sformatf("v%0d_gone", i), 32'(ds_to_es_valid), 32'd0);
         next_cycle();
      end

      // ---- RAW stall on rs via EX, fetch held off, then simultaneous
      //      transfer and accept with no bubble
      regs[1] = 32'd5;
      regs[2] = 32'd9;
      es_dest = 5'd1;
      fs_to_ds_valid = 1'b1; fs_inst = 32'h2423FFFF; fs_pc = 32'h100;
      next_cycle();
      fs_inst = 32'h00221821; fs_pc = 32'h104;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("haz_to_es", 32'(ds_to_es_valid), 32'd0);
         chk("haz_allowin", 32'(ds_allowin), 32'd0);
         chk("haz_pc", ds_pc, 32'h100);
         next_cycle();
      end
      es_dest = 5'd0;
      @(negedge clk);
      chk("haz_clear_to_es", 32'(ds_to_es_valid), 32'd1);
      chk("haz_clear_allowin", 32'(ds_allowin), 32'd1);
      chk("haz_clear_src1", ds_alu_src1, 32'd5);
      next_cycle();
      fs_to_ds_valid = 1'b0;
      @(negedge clk);
      chk("b2b_to_es", 32'(ds_to_es_valid), 32'd1);
      chk("b2b_pc", ds_pc, 32'h104);
      chk("b2b_src2", ds_alu_src2, 32'd9);
      next_cycle();

      // ---- RAW stall on rt via WB
      ws_dest = 5'd2;
      fs_to_ds_valid = 1'b1; fs_inst = 32'h00221821; fs_pc = 32'h108;
      next_cycle();
      fs_to_ds_valid = 1'b0;
      @(negedge clk);
      chk("rt_haz_to_es", 32'(ds_to_es_valid), 32'd0);
      ws_dest = 5'd0;
      #1;
      chk("rt_haz_clear", 32'(ds_to_es_valid), 32'd1);
      next_cycle();

      // ---- rs = $0 and a match on the unused rt never stall
      es_dest = 5'd3;
      fs_to_ds_valid = 1'b1; fs_inst = 32'h2403FFFF; fs_pc = 32'h10C;
      next_cycle();
      fs_to_ds_valid = 1'b0;
      @(negedge clk);
      chk("r0_to_es", 32'(ds_to_es_valid), 32'd1);
      chk("r0_src1", ds_alu_src1, 32'd0);
      es_dest = 5'd0;
      next_cycle();

      // ---- execute back-pressure for 2 cycles, then flush while held
      es_allowin = 1'b0;
      fs_to_ds_valid = 1'b1; fs_inst = 32'h00221821; fs_pc = 32'h300;
      next_cycle();
      fs_inst = 32'h34C58001; fs_pc = 32'h304;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("bp_to_es", 32'(ds_to_es_valid), 32'd1);
         chk("bp_allowin", 32'(ds_allowin), 32'd0);
         chk("bp_pc", ds_pc, 32'h300);
         chk("bp_ctrl", 32'(ds_alu_control), 32'h001);
         next_cycle();
      end
      es_allowin = 1'b1;
      @(negedge clk);
      chk("bp_release_allowin", 32'(ds_allowin), 32'd1);
      chk("bp_release_pc", ds_pc, 32'h300);
      next_cycle();
      fs_to_ds_valid = 1'b0;
      es_allowin = 1'b0;
      @(negedge clk);
      chk("bp_next_pc", ds_pc, 32'h304);
      chk("bp_next_dest", 32'(ds_dest), 32'd5);
      flush = 1'b1;
      #1;
      chk("flush_to_es", 32'(ds_to_es_valid), 32'd0);
      next_cycle();
      flush = 1'b0;
      es_allowin = 1'b1;
      @(negedge clk);
      chk("flush_allowin", 32'(ds_allowin), 32'd1);
      chk("flush_to_es_after", 32'(ds_to_es_valid), 32'd0);
      chk("flush_ctrl", 32'(ds_alu_control), 32'd0);
      next_cycle();

      // ---- asynchronous reset mid-operation
      es_allowin = 1'b0;
      fs_to_ds_valid = 1'b1; fs_inst = 32'h3C021234; fs_pc = 32'h500;
      next_cycle();
      fs_to_ds_valid = 1'b0;
      @(negedge clk);
      chk("arst_before", 32'(ds_to_es_valid), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_to_es", 32'(ds_to_es_valid), 32'd0);
      chk("arst_pc", ds_pc, 32'd0);
      chk("arst_allowin", 32'(ds_allowin), 32'd1);
      next_cycle();
      resetn = 1'b1;
      es_allowin = 1'b1;
      next_cycle();

      // ---- randomized traffic against the model
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      m_valid = 1'b0; m_inst = '0; m_pc = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         fs_to_ds_valid = ($urandom_range(0, 3) != 0);
         fs_inst = gen_inst();
         fs_pc = $urandom;
         es_allowin = ($urandom_range(0, 3) != 0);
         es_dest = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 7)) : 5'd0;
         ms_dest = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 7)) : 5'd0;
         ws_dest = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 7)) : 5'd0;
         flush = ($urandom_range(0, 15) == 0);
         regs[$urandom_range(1, 7)] = $urandom;
         @(negedge clk);
         r = ref_decode(m_inst);
         m_haz = m_valid && ((r.rs_used && busy(m_inst[25:21])) ||
                             (r.rt_used && busy(m_inst[20:16])));
         m_allow = !m_valid || (!m_haz && es_allowin);
         m_to_es = m_valid && !m_haz && !flush;
         chk("rnd_allowin", 32'(ds_allowin), 32'(m_allow));
         chk("rnd_to_es", 32'(ds_to_es_valid), 32'(m_to_es));
         if (m_valid) begin
            chk("rnd_ctrl", 32'(ds_alu_control), 32'(r.ctrl));
            chk("rnd_dest", 32'(ds_dest), 32'(r.dest));
            chk("rnd_ri", 32'(ds_ri), 32'(r.ri));
            chk("rnd_pc", ds_pc, m_pc);
            if (!r.ri) begin
               chk("rnd_src1", ds_alu_src1, r.src1);
               chk("rnd_src2", ds_alu_src2, r.src2);
            end
         end else begin
            chk("rnd_idle_ctrl", 32'(ds_alu_control), 32'd0);
            chk("rnd_idle_dest", 32'(ds_dest), 32'd0);
         end
         if (fs_to_ds_valid && m_allow && !flush) begin
            m_inst = fs_inst;
            m_pc = fs_pc;
         end
         if (flush) m_valid = 1'b0;
         else if (m_allow) m_valid = fs_to_ds_valid;
         next_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
